// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: default widths and elaboration helpers shared by the fetch queue files.
// Ports: none (package).
package fetch_queue_pkg;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_INSTR_W = 32;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_PRED_W  = 2;

    // Packed entry layout, LSB first: Instr, PC, PC+4, taken bit, predictor bits.
    function automatic int entry_w(int iw, int aw, int pw);
        return iw + 2 * aw + 1 + pw;
    endfunction

    function automatic bit depth_ok(int d);
        return d >= 2 && (d & (d - 1)) == 0;
    endfunction
endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: IF-side push channel, ID-side head/pop channel and control for fetch_queue.
// Ports: master drives FLUSH/STALL/Valid_IF/fetch fields and reads head and status;
//        slave is the queue itself.
interface fetch_queue_if import fetch_queue_pkg::*; #(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int PRED_W  = DEF_PRED_W
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic               FLUSH;
    logic               STALL;
    logic               Valid_IF;
    logic               Ready_IF;
    logic [INSTR_W-1:0] Instr1_IF;
    logic [ADDR_W-1:0]  Instr_PC_IF;
    logic [ADDR_W-1:0]  Instr_PC_Plus4_IF;
    logic               Branch_prediction_IN;
    logic [PRED_W-1:0]  Branch_predictions_IN;
    logic               Valid_OUT;
    logic [INSTR_W-1:0] Instr1_OUT;
    logic [ADDR_W-1:0]  Instr_PC_OUT;
    logic [ADDR_W-1:0]  Instr_PC_Plus4;
    logic               Branch_prediction_OUT;
    logic [PRED_W-1:0]  Branch_predictions_OUT;
    logic [CNT_W-1:0]   Count_OUT;
    logic               Full_OUT;
    logic               Empty_OUT;

    modport master (
        output FLUSH, STALL, Valid_IF, Instr1_IF, Instr_PC_IF, Instr_PC_Plus4_IF,
               Branch_prediction_IN, Branch_predictions_IN,
        input  Ready_IF, Valid_OUT, Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4,
               Branch_prediction_OUT, Branch_predictions_OUT, Count_OUT, Full_OUT, Empty_OUT
    );

    modport slave (
        input  FLUSH, STALL, Valid_IF, Instr1_IF, Instr_PC_IF, Instr_PC_Plus4_IF,
               Branch_prediction_IN, Branch_predictions_IN,
        output Ready_IF, Valid_OUT, Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4,
               Branch_prediction_OUT, Branch_predictions_OUT, Count_OUT, Full_OUT, Empty_OUT
    );
endinterface

// File: rtl/fetch_queue_fifo_ptr_ctrl.sv
// fifo_ptr_ctrl: read/write pointers, occupancy, full/empty and push/pop qualification.
// Ports: clk, rst_n (async active-low); flush, valid_in, stall in;
//        push, pop, wr_ptr, rd_ptr, count, full, empty out.
module fifo_ptr_ctrl #(
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             valid_in,
    input  logic             stall,
    output logic             push,
    output logic             pop,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign full   = count_q == CNT_W'(DEPTH);
    assign empty  = count_q == '0;
    assign wr_ptr = wr_ptr_q;
    assign rd_ptr = rd_ptr_q;
    assign count  = count_q;

    // Flush overrides both handshakes; pointers wrap naturally since DEPTH is a power of 2.
    always_comb begin
        push     = valid_in & ~full & ~flush;
        pop      = ~empty & ~stall & ~flush;
        wr_ptr_d = flush ? '0 : wr_ptr_q + PTR_W'(push);
        rd_ptr_d = flush ? '0 : rd_ptr_q + PTR_W'(pop);
        count_d  = flush ? '0 : count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry FIFO of fetched instructions between IF and ID.
// Ports: CLK, RESET (async active-low); bus (fetch_queue_if.slave) carrying FLUSH, STALL,
//        IF push channel with Ready_IF, head outputs for ID, Count_OUT, Full_OUT, Empty_OUT.
module fetch_queue import fetch_queue_pkg::*; #(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int PRED_W  = DEF_PRED_W
) (
    input logic          CLK,
    input logic          RESET,
    fetch_queue_if.slave bus
);
    localparam int EW    = entry_w(INSTR_W, ADDR_W, PRED_W);
    localparam int PTR_W = $clog2(DEPTH);

    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("fetch_queue: DEPTH must be a power of 2 and >= 2");
    end

    logic             push, pop, full, empty;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [EW-1:0]    mem_q [DEPTH];
    logic [EW-1:0]    mem_d [DEPTH];
    logic [EW-1:0]    head;

    fifo_ptr_ctrl #(.DEPTH(DEPTH)) u_ctrl (
        .clk      (CLK),
        .rst_n    (RESET),
        .flush    (bus.FLUSH),
        .valid_in (bus.Valid_IF),
        .stall    (bus.STALL),
        .push     (push),
        .pop      (pop),
        .wr_ptr   (wr_ptr),
        .rd_ptr   (rd_ptr),
        .count    (bus.Count_OUT),
        .full     (full),
        .empty    (empty)
    );

    always_comb begin
        mem_d = mem_q;
        if (push)
            mem_d[wr_ptr] = {bus.Branch_predictions_IN, bus.Branch_prediction_IN,
                             bus.Instr_PC_Plus4_IF, bus.Instr_PC_IF, bus.Instr1_IF};
    end

    // Storage is not reset: the head is masked to zero whenever the queue is empty.
    always_ff @(posedge CLK) mem_q <= mem_d;

    assign head          = empty ? '0 : mem_q[rd_ptr];
    assign {bus.Branch_predictions_OUT, bus.Branch_prediction_OUT,
            bus.Instr_PC_Plus4, bus.Instr_PC_OUT, bus.Instr1_OUT} = head;
    assign bus.Valid_OUT = ~empty;
    assign bus.Empty_OUT = empty;
    assign bus.Full_OUT  = full;
    assign bus.Ready_IF  = ~full;

    logic unused;
    assign unused = pop;
endmodule
